// File: rtl/tt_um_div8_seq_if.sv
// tt_um_div8_seq_if: TinyTapeout tile pins for the divider (ena, ui_in, uio_in in; uo_out, uio_out, uio_oe out)
interface tt_um_div8_seq_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_um_div8_seq.sv
// tt_um_div8_seq: 8-bit sequential restoring divider.
// Ports: clk, rst_n (async active-low), bus (slave modport):
//   ena tile enable; ui_in operand byte; uio_in[0] load_a, [1] load_b, [2] start, [3] sel;
//   uo_out quotient (sel=0) or remainder (sel=1); uio_out[7:5] busy/done/dz; uio_oe constant 8'hE0.
module tt_um_div8_seq (
  input logic clk,
  input logic rst_n,
  tt_um_div8_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_state;
  logic [7:0] r_a, r_b, r_quo, r_q, r_r, w_a, w_b, w_quo, w_q, w_r;
  logic [8:0] r_rem, w_rem, w_t, w_diff;
  logic [3:0] r_cnt, w_cnt;
  logic       r_busy, r_done, r_dz, w_busy, w_done, w_dz, w_ge, w_ld, w_start, w_unused;
  assign w_unused = &{1'b0, bus.uio_in[7:4]};
  assign w_start = bus.uio_in[2];
  assign w_ld = r_state != RUN;
  assign w_t = {r_rem[7:0], r_quo[7]};
  assign w_ge = w_t >= {1'b0, r_b};
  assign w_diff = w_ge ? w_t - {1'b0, r_b} : w_t;
  always_comb begin
    w_state = r_state;
    w_a = w_ld && bus.uio_in[0] ? bus.ui_in : r_a;
    w_b = w_ld && bus.uio_in[1] ? bus.ui_in : r_b;
    w_rem = r_rem;
    w_quo = r_quo;
    w_cnt = r_cnt;
    w_q = r_q;
    w_r = r_r;
    w_busy = r_busy;
    w_done = r_done;
    w_dz = r_dz;
    if (r_state == RUN) begin
      w_rem = w_diff;
      w_quo = {r_quo[6:0], w_ge};
      w_cnt = r_cnt + 4'd1;
      if (r_cnt == 4'd7) begin
        w_q = {r_quo[6:0], w_ge};
        w_r = w_diff[7:0];
        w_busy = 1'b0;
        w_done = 1'b1;
        w_state = DONE;
      end
    end else if (w_start) begin
      w_rem = 9'd0;
      w_quo = r_a;
      w_cnt = 4'd0;
      w_dz = r_b == 8'd0;
      w_done = 1'b0;
      w_busy = 1'b1;
      w_state = RUN;
    end else if (r_state == DONE && (bus.uio_in[0] || bus.uio_in[1])) begin
      w_done = 1'b0;
      w_state = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a <= '0;
      r_b <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_cnt <= '0;
      r_q <= '0;
      r_r <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dz <= 1'b0;
    end else if (bus.ena) begin
      r_state <= w_state;
      r_a <= w_a;
      r_b <= w_b;
      r_rem <= w_rem;
      r_quo <= w_quo;
      r_cnt <= w_cnt;
      r_q <= w_q;
      r_r <= w_r;
      r_busy <= w_busy;
      r_done <= w_done;
      r_dz <= w_dz;
    end
  end
  assign bus.uo_out = bus.uio_in[3] ? r_r : r_q;
  assign bus.uio_out = {r_busy, r_done, r_dz, 5'b0};
  assign bus.uio_oe = 8'hE0;
endmodule

// File: tb/tb_tt_um_div8_seq.sv
// tb_tt_um_div8_seq: scoreboard bench for the sequential divider
module tb_tt_um_div8_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  tt_um_div8_seq_if io();
  tt_um_div8_seq dut (.clk(clk), .rst_n(rst_n), .bus(io));
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [7:0] ma = 8'd0;
  logic [7:0] mb = 8'd0;
  logic [15:0] sb[$];
  logic [15:0] e;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b);
    io.ui_in = a;
    io.uio_in = 8'h01;
    tick();
    ma = a;
    io.ui_in = b;
    io.uio_in = 8'h02;
    tick();
    mb = b;
    io.uio_in = 8'h00;
  endtask

  task automatic push_exp();
    sb.push_back(mb == 8'd0 ? {8'hFF, ma} : {ma / mb, ma % mb});
  endtask

  task automatic start_op();
    io.uio_in = 8'h04;
    tick();
    io.uio_in = 8'h00;
    push_exp();
    cyc = 0;
  endtask

  task automatic wait_done();
    while (io.uio_out[6] !== 1'b1 && cyc < 60) tick();
  endtask

  task automatic test_reset();
    io.ena = 1'b1;
    io.ui_in = 8'h00;
    io.uio_in = 8'h00;
    #1 rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if (io.uo_out !== 8'h00) begin n_fail++; $display("FAIL reset_uo_out: got %h want 00", io.uo_out); end
    n_checks++;
    if (io.uio_out !== 8'h00) begin n_fail++; $display("FAIL reset_uio_out: got %h want 00", io.uio_out); end
    n_checks++;
    if (io.uio_oe !== 8'hE0) begin n_fail++; $display("FAIL reset_uio_oe: got %h want e0", io.uio_oe); end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (io.uio_out !== 8'h00) begin n_fail++; $display("FAIL post_reset_status: got %h want 00", io.uio_out); end
  endtask

  task automatic test_basic();
    int nb = 0;
    load(8'd200, 8'd7);
    start_op();
    n_checks++;
    if (io.uio_out[5] !== 1'b0) begin n_fail++; $display("FAIL basic_dz: got %b want 0", io.uio_out[5]); end
    while (io.uio_out[6] !== 1'b1 && cyc < 60) begin
      if (io.uio_out[7] === 1'b1) nb++;
      tick();
    end
    n_checks++;
    if (nb != 8) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 8", nb); end
    n_checks++;
    if (cyc != 8) begin n_fail++; $display("FAIL basic_latency: got %0d want 8", cyc); end
    n_checks++;
    if (io.uio_out[7:6] !== 2'b01) begin n_fail++; $display("FAIL basic_busy_done: got %b want 01", io.uio_out[7:6]); end
    e = sb.pop_front();
    io.uio_in[3] = 1'b0; #1;
    n_checks++;
    if (io.uo_out !== e[15:8]) begin n_fail++; $display("FAIL basic_quo: got %0d want %0d", io.uo_out, e[15:8]); end
    io.uio_in[3] = 1'b1; #1;
    n_checks++;
    if (io.uo_out !== e[7:0]) begin n_fail++; $display("FAIL basic_rem: got %0d want %0d", io.uo_out, e[7:0]); end
    io.uio_in[3] = 1'b0;
  endtask

  task automatic test_back_to_back();
    load(8'd255, 8'd1);
    io.uio_in = 8'h04;
    tick();
    push_exp();
    cyc = 0;
    wait_done();
    n_checks++;
    if (cyc != 8) begin n_fail++; $display("FAIL b2b_latency1: got %0d want 8", cyc); end
    e = sb.pop_front();
    n_checks++;
    if (io.uo_out !== e[15:8]) begin n_fail++; $display("FAIL b2b_quo1: got %0d want %0d", io.uo_out, e[15:8]); end
    tick();
    push_exp();
    cyc = 0;
    n_checks++;
    if (io.uio_out[7:6] !== 2'b10) begin n_fail++; $display("FAIL b2b_reaccept: got %b want 10", io.uio_out[7:6]); end
    wait_done();
    io.uio_in = 8'h00;
    n_checks++;
    if (cyc != 8) begin n_fail++; $display("FAIL b2b_done_low: got %0d want 8", cyc); end
    e = sb.pop_front();
    io.uio_in[3] = 1'b1; #1;
    n_checks++;
    if (io.uo_out !== e[7:0]) begin n_fail++; $display("FAIL b2b_rem2: got %0d want %0d", io.uo_out, e[7:0]); end
    io.uio_in[3] = 1'b0;
    load(8'd5, 8'd9);
    start_op();
    wait_done();
    e = sb.pop_front();
    #1;
    n_checks++;
    if (io.uo_out !== e[15:8]) begin n_fail++; $display("FAIL b2b_quo3: got %0d want %0d", io.uo_out, e[15:8]); end
    io.uio_in[3] = 1'b1; #1;
    n_checks++;
    if (io.uo_out !== e[7:0]) begin n_fail++; $display("FAIL b2b_rem3: got %0d want %0d", io.uo_out, e[7:0]); end
    io.uio_in[3] = 1'b0;
  endtask

  task automatic test_div_zero();
    load(8'd100, 8'd0);
    start_op();
    n_checks++;
    if (io.uio_out[5] !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b want 1", io.uio_out[5]); end
    wait_done();
    n_checks++;
    if (cyc != 8) begin n_fail++; $display("FAIL dz_latency: got %0d want 8", cyc); end
    e = sb.pop_front();
    #1;
    n_checks++;
    if (io.uo_out !== e[15:8]) begin n_fail++; $display("FAIL dz_quo: got %h want %h", io.uo_out, e[15:8]); end
    io.uio_in[3] = 1'b1; #1;
    n_checks++;
    if (io.uo_out !== e[7:0]) begin n_fail++; $display("FAIL dz_rem: got %0d want %0d", io.uo_out, e[7:0]); end
    io.uio_in[3] = 1'b0;
    n_checks++;
    if (io.uio_out[5] !== 1'b1) begin n_fail++; $display("FAIL dz_hold: got %b want 1", io.uio_out[5]); end
  endtask

  task automatic test_run_ignore();
    load(8'd200, 8'd7);
    start_op();
    tick();
    tick();
    io.ui_in = 8'd3;
    io.uio_in = 8'h06;
    tick();
    io.uio_in = 8'h00;
    wait_done();
    n_checks++;
    if (cyc != 8) begin n_fail++; $display("FAIL ign_latency: got %0d want 8", cyc); end
    e = sb.pop_front();
    #1;
    n_checks++;
    if (io.uo_out !== e[15:8]) begin n_fail++; $display("FAIL ign_quo: got %0d want %0d", io.uo_out, e[15:8]); end
    io.uio_in[3] = 1'b1; #1;
    n_checks++;
    if (io.uo_out !== e[7:0]) begin n_fail++; $display("FAIL ign_rem: got %0d want %0d", io.uo_out, e[7:0]); end
    io.uio_in[3] = 1'b0;
    start_op();
    tick();
    n_checks++;
    if (io.uo_out !== e[15:8]) begin n_fail++; $display("FAIL ena_run_hold: got %0d want %0d", io.uo_out, e[15:8]); end
    io.ena = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (io.uio_out[7:6] !== 2'b10) begin n_fail++; $display("FAIL ena_freeze: got %b want 10", io.uio_out[7:6]); end
    io.ena = 1'b1;
    wait_done();
    n_checks++;
    if (cyc != 11) begin n_fail++; $display("FAIL ena_latency: got %0d want 11", cyc); end
    e = sb.pop_front();
    #1;
    n_checks++;
    if (io.uo_out !== e[15:8]) begin n_fail++; $display("FAIL ena_quo: got %0d want %0d", io.uo_out, e[15:8]); end
  endtask

  task automatic test_async_reset();
    load(8'd200, 8'd7);
    start_op();
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (io.uio_out !== 8'h00) begin n_fail++; $display("FAIL areset_status: got %h want 00", io.uio_out); end
    n_checks++;
    if (io.uo_out !== 8'h00) begin n_fail++; $display("FAIL areset_uo_out: got %h want 00", io.uo_out); end
    void'(sb.pop_front());
    ma = 8'd0;
    mb = 8'd0;
    #2 rst_n = 1'b1;
    tick();
    n_checks++;
    if (io.uio_out[7:6] !== 2'b00) begin n_fail++; $display("FAIL areset_idle: got %b want 00", io.uio_out[7:6]); end
    load(8'd9, 8'd3);
    start_op();
    wait_done();
    n_checks++;
    if (cyc != 8) begin n_fail++; $display("FAIL areset_latency: got %0d want 8", cyc); end
    e = sb.pop_front();
    #1;
    n_checks++;
    if (io.uo_out !== e[15:8]) begin n_fail++; $display("FAIL areset_quo: got %0d want %0d", io.uo_out, e[15:8]); end
    io.uio_in[3] = 1'b1; #1;
    n_checks++;
    if (io.uo_out !== e[7:0]) begin n_fail++; $display("FAIL areset_rem: got %0d want %0d", io.uo_out, e[7:0]); end
    io.uio_in[3] = 1'b0;
  endtask

  task automatic test_load_from_done();
    io.ui_in = 8'd50;
    io.uio_in = 8'h01;
    tick();
    ma = 8'd50;
    io.uio_in = 8'h00;
    n_checks++;
    if (io.uio_out[6] !== 1'b0) begin n_fail++; $display("FAIL ld_done_clear: got %b want 0", io.uio_out[6]); end
    n_checks++;
    if (io.uo_out !== e[15:8]) begin n_fail++; $display("FAIL ld_result_kept: got %0d want %0d", io.uo_out, e[15:8]); end
    io.ui_in = 8'd7;
    io.uio_in = 8'h02;
    tick();
    mb = 8'd7;
    io.uio_in = 8'h00;
    start_op();
    wait_done();
    n_checks++;
    if (io.uio_out[6] !== 1'b1) begin n_fail++; $display("FAIL ld_timeout: got %b want 1", io.uio_out[6]); end
    e = sb.pop_front();
    #1;
    n_checks++;
    if (io.uo_out !== e[15:8]) begin n_fail++; $display("FAIL ld_quo: got %0d want %0d", io.uo_out, e[15:8]); end
    io.uio_in[3] = 1'b1; #1;
    n_checks++;
    if (io.uo_out !== e[7:0]) begin n_fail++; $display("FAIL ld_rem: got %0d want %0d", io.uo_out, e[7:0]); end
    io.uio_in[3] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_run_ignore();
    test_async_reset();
    test_load_from_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
